// File: rtl/cpu_ext_pkg.sv
// Shared definitions for the immediate-extension datapath: extend modes,
// default word widths reused by the decoder and ALU, and the skid-buffer
// occupancy encoding used by sign_extend_pipe.
package cpu_ext_pkg;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    EXT_SIGN   = 2'b00,
    EXT_ZERO   = 2'b01,
    EXT_UPPER  = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_mode_t;

  // Encoded as {skid_full, out_valid} so both flags read straight off the state.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b11
  } buf_state_t;

endpackage

// File: rtl/sign_extend_pipe_ext_func.sv
// ext_func: purely combinational immediate extender (sign, zero, upper,
// branch-offset). Shared by the pipelined extender and the decoder model.
module ext_func
  import cpu_ext_pkg::*;
#(
  parameter int IN_W     = IMM_W,
  parameter int OUT_W    = WORD_W,
  parameter int SHIFT_BR = 2
) (
  input  logic [IN_W-1:0]  imm_i,
  input  ext_mode_t        mode_i,
  output logic [OUT_W-1:0] result_o
);

  logic [OUT_W-1:0] sign_ext;

  assign sign_ext = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

  // Select the extension; branch bits pushed past the MSB simply fall off.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves result_o unassigned (no latch).
    result_o = sign_ext;
    unique case (mode_i)
      EXT_SIGN:   result_o = sign_ext;
      EXT_ZERO:   result_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
      EXT_UPPER:  result_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
      EXT_BRANCH: result_o = sign_ext << SHIFT_BR;
      default:    ;
    endcase
  end

endmodule

// File: rtl/sign_extend_pipe.sv
// sign_extend_pipe: registered immediate extender with a valid/ready
// handshake and a 2-entry (main + skid) buffer so the consumer can stall
// without losing an immediate. InReady is a pure register output.
// Optional build macro EXT_COUNT_EN adds the saturating OutCount port.
module sign_extend_pipe
  import cpu_ext_pkg::*;
#(
  parameter int IN_W     = IMM_W,
  parameter int OUT_W    = WORD_W,
  parameter int SHIFT_BR = 2,
  parameter int TAG_W    = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [IN_W-1:0]  InImm,
  input  logic [1:0]       InMode,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [OUT_W-1:0] OutData,
  output logic [TAG_W-1:0] OutTag
`ifdef EXT_COUNT_EN
  ,
  output logic [15:0]      OutCount
`endif
);

  if (IN_W < 1 || IN_W >= OUT_W) begin : g_bad_in_w
    $fatal(1, "sign_extend_pipe: IN_W must be in 1..OUT_W-1");
  end
  if (SHIFT_BR < 0 || SHIFT_BR >= OUT_W) begin : g_bad_shift
    $fatal(1, "sign_extend_pipe: SHIFT_BR must be in 0..OUT_W-1");
  end

  buf_state_t       state_q, state_d;
  logic [OUT_W-1:0] main_data_q, main_data_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic [OUT_W-1:0] ext_result;
  logic             in_xfer;
  logic             out_xfer;

  ext_func #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .SHIFT_BR (SHIFT_BR)
  ) u_ext_func (
    .imm_i    (InImm),
    .mode_i   (ext_mode_t'(InMode)),
    .result_o (ext_result)
  );

  assign InReady  = ~state_q[1];
  assign OutValid = state_q[0];
  assign OutData  = main_data_q;
  assign OutTag   = main_tag_q;
  assign in_xfer  = InValid & InReady;
  assign out_xfer = OutValid & OutReady;

  // Buffer occupancy transitions and which register captures new data.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_tag_d  = main_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    case (state_q)
      BUF_EMPTY: begin
        if (in_xfer) begin
          main_data_d = ext_result;
          main_tag_d  = InTag;
          state_d     = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (in_xfer && out_xfer) begin
          main_data_d = ext_result;
          main_tag_d  = InTag;
        end else if (in_xfer) begin
          skid_data_d = ext_result;
          skid_tag_d  = InTag;
          state_d     = BUF_FULL;
        end else if (out_xfer) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // Older skid entry moves forward; nothing new can arrive while full.
        if (out_xfer) begin
          main_data_d = skid_data_q;
          main_tag_d  = skid_tag_q;
          state_d     = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // State and data registers; reset drops any in-flight entries.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      // NOTE: data registers are reset too, so OutData/OutTag read 0 after reset rather than X.
      state_q     <= BUF_EMPTY;
      main_data_q <= '0;
      main_tag_q  <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_tag_q  <= main_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

`ifdef EXT_COUNT_EN
  logic [15:0] count_q;

  // Count accepted inputs, sticking at all-ones instead of wrapping.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else if (in_xfer && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign OutCount = count_q;
`endif

endmodule

// File: tb/tb_sign_extend_pipe.sv
// Self-checking bench for sign_extend_pipe: a capacity-2 FIFO reference
// model plus an arithmetic model of the extend modes.
module tb_sign_extend_pipe;

  localparam int IN_W     = 16;
  localparam int OUT_W    = 32;
  localparam int SHIFT_BR = 2;
  localparam int TAG_W    = 4;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic [IN_W-1:0]  InImm;
  logic [1:0]       InMode;
  logic [TAG_W-1:0] InTag;
  logic             OutValid;
  logic             OutReady;
  logic [OUT_W-1:0] OutData;
  logic [TAG_W-1:0] OutTag;
`ifdef EXT_COUNT_EN
  logic [15:0]      OutCount;
`endif

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t q[$];
  int   cnt_model = 0;
  int   checks    = 0;
  int   errors    = 0;

  sign_extend_pipe #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .SHIFT_BR (SHIFT_BR),
    .TAG_W    (TAG_W)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .InImm    (InImm),
    .InMode   (InMode),
    .InTag    (InTag),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutData  (OutData),
    .OutTag   (OutTag)
`ifdef EXT_COUNT_EN
    ,
    .OutCount (OutCount)
`endif
  );

  always #5 CLK = ~CLK;

  // Arithmetic model: interpret the immediate as a number and scale it.
  function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] imm, input logic [1:0] mode);
    longint      s;
    longint      r;
    logic [63:0] rr;
    s = longint'(imm);
    if (s >= (longint'(1) << (IN_W - 1))) s = s - (longint'(1) << IN_W);
    case (mode)
      2'd0:    r = s;
      2'd1:    r = longint'(imm);
      2'd2:    r = longint'(imm) * (longint'(1) << (OUT_W - IN_W));
      default: r = s * (longint'(1) << SHIFT_BR);
    endcase
    rr = r;
    return rr[OUT_W-1:0];
  endfunction

  // Advance one clock, updating the reference FIFO with the handshakes it implies.
  task automatic step();
    bit   in_x;
    bit   out_x;
    ent_t e;
    in_x   = InValid && (q.size() < 2);
    out_x  = OutReady && (q.size() > 0);
    e.data = ref_ext(InImm, InMode);
    e.tag  = InTag;
    @(posedge CLK);
    if (out_x) q.delete(0);
    if (in_x) begin
      q.push_back(e);
      if (cnt_model != 65535) cnt_model++;
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; InValid = 1'b0; InImm = '0; InMode = '0; InTag = '0; OutReady = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK) Reset = 1'b0;
    @(posedge CLK); #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got=%b exp=1", InReady); end
    checks++; if (OutData !== '0) begin errors++; $display("FAIL reset_outdata got=%h exp=0", OutData); end
    checks++; if (OutTag !== '0) begin errors++; $display("FAIL reset_outtag got=%h exp=0", OutTag); end
`ifdef EXT_COUNT_EN
    checks++; if (OutCount !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", OutCount); end
`endif
  endtask

  task automatic test_modes();
    logic [OUT_W-1:0] exp_tab [4];
    exp_tab[0] = 32'hFFFF8001; exp_tab[1] = 32'h00008001;
    exp_tab[2] = 32'h80010000; exp_tab[3] = 32'hFFFE0004;
    OutReady = 1'b1;
    for (int m = 0; m < 4; m++) begin
      InValid = 1'b1; InImm = 16'h8001; InMode = 2'(m); InTag = 4'(m);
      step();
      checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid got=%b exp=1", m, OutValid); end
      checks++; if (OutData !== exp_tab[m] || OutTag !== 4'(m))
        begin errors++; $display("FAIL mode%0d_data got=%h/%h exp=%h/%h", m, OutData, OutTag, exp_tab[m], m); end
    end
    InValid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    OutReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      InValid = 1'b1; InImm = IN_W'($urandom); InMode = 2'($urandom); InTag = 4'(i);
      step();
      checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL b2b_inready[%0d] got=%b exp=1", i, InReady); end
      checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, OutValid); end
      checks++; if (OutTag !== 4'(i)) begin errors++; $display("FAIL b2b_tag[%0d] got=%0d exp=%0d", i, OutTag, i); end
      checks++; if (OutData !== q[0].data) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, OutData, q[0].data); end
    end
    InValid = 1'b0;
    step();
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", OutValid); end
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] held;
    OutReady = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      InValid = 1'b1; InImm = IN_W'($urandom); InMode = 2'($urandom); InTag = 4'(t);
      step();
    end
    InValid = 1'b0;
    held = q[0].data;
    for (int c = 0; c < 3; c++) begin
      checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL bp_inready_low[%0d] got=%b exp=0", c, InReady); end
      checks++; if (OutTag !== 4'd1 || OutData !== held)
        begin errors++; $display("FAIL bp_hold[%0d] got=%h/%0d exp=%h/1", c, OutData, OutTag, held); end
      step();
    end
    OutReady = 1'b1;
    step();
    checks++; if (OutTag !== 4'd2 || OutData !== q[0].data)
      begin errors++; $display("FAIL bp_second got=%h/%0d exp=%h/2", OutData, OutTag, q[0].data); end
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL bp_inready_back got=%b exp=1", InReady); end
    step();
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", OutValid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      InValid = ($urandom_range(0, 3) != 0);
      InImm = IN_W'($urandom); InMode = 2'($urandom); InTag = 4'($urandom);
      if (i < 500) OutReady = (i % 2 == 0);
      else         OutReady = 1'($urandom_range(0, 1));
      step();
      checks++; if (OutValid !== (q.size() > 0))
        begin errors++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, OutValid, q.size() > 0); end
      checks++; if (InReady !== (q.size() < 2))
        begin errors++; $display("FAIL rand_inready[%0d] got=%b exp=%b", i, InReady, q.size() < 2); end
      if (q.size() > 0) begin
        checks++; if (OutData !== q[0].data || OutTag !== q[0].tag)
          begin errors++; $display("FAIL rand_data[%0d] got=%h/%h exp=%h/%h", i, OutData, OutTag, q[0].data, q[0].tag); end
      end
    end
    InValid = 1'b0; OutReady = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    OutReady = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      InValid = 1'b1; InImm = IN_W'($urandom); InMode = 2'($urandom); InTag = 4'(t + 4);
      step();
    end
    InValid = 1'b0;
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL rm_full got=%b exp=0", InReady); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rm_async_valid got=%b exp=0", OutValid); end
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL rm_async_inready got=%b exp=1", InReady); end
    q.delete();
    cnt_model = 0;
    @(negedge CLK) Reset = 1'b0;
    @(posedge CLK); #1;
    OutReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rm_stale[%0d] got=%b/%0d exp=0", c, OutValid, OutTag); end
    end
    InValid = 1'b1; InImm = 16'h1234; InMode = 2'd1; InTag = 4'd9;
    step();
    InValid = 1'b0;
    checks++; if (OutValid !== 1'b1 || OutTag !== 4'd9 || OutData !== 32'h00001234)
      begin errors++; $display("FAIL rm_after got=%b/%0d/%h exp=1/9/00001234", OutValid, OutTag, OutData); end
    step();
  endtask

`ifdef EXT_COUNT_EN
  task automatic test_count();
    @(negedge CLK) Reset = 1'b1;
    @(negedge CLK) Reset = 1'b0;
    @(posedge CLK); #1;
    q.delete();
    cnt_model = 0;
    OutReady = 1'b1;
    InValid = 1'b1; InImm = IN_W'($urandom); InMode = 2'($urandom); InTag = 4'($urandom);
    repeat (5) step();
    InValid = 1'b0;
    step();
    checks++; if (OutCount !== 16'd5) begin errors++; $display("FAIL count_5 got=%0d exp=5", OutCount); end
    InValid = 1'b1;
    repeat (65540) step();
    InValid = 1'b0;
    step();
    checks++; if (OutCount !== 16'hFFFF || cnt_model != 65535)
      begin errors++; $display("FAIL count_sat got=%h exp=ffff", OutCount); end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef EXT_COUNT_EN
    test_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
